// File: rtl/port_in_buffer_if.sv
// rtl/port_in_buffer_if.sv - ingress and head-presentation signal bundle for port_in_buffer
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface port_in_buffer_if #(
  parameter int PORT_NUB   = `PORT_NUB_TOTAL,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  localparam int DEST_W = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [DEST_W-1:0]     in_dest;
  logic [PORT_NUB-1:0]   full_in;
  logic                  grant_in;
  logic [PORT_NUB-1:0]   vaild_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DEST_W-1:0]     dest_out;

  modport master (
    output in_valid, in_data, in_dest, full_in, grant_in,
    input  in_ready, vaild_out, data_out, dest_out
  );

  modport slave (
    input  in_valid, in_data, in_dest, full_in, grant_in,
    output in_ready, vaild_out, data_out, dest_out
  );
endinterface

// File: rtl/port_in_buffer.sv
// rtl/port_in_buffer.sv - per-port ingress FIFO presenting a one-hot destination request for its head word
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module port_in_buffer #(
  parameter int PORT_NUB   = `PORT_NUB_TOTAL,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  port_in_buffer_if.slave         bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    dest_err,
  output logic [15:0]             acc_cnt
);
  localparam int DEST_W = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DST1_W = DEST_W + 1;
  localparam int WORD_W = DEST_W + DATA_WIDTH;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [WORD_W-1:0] head;
  logic              take;
  logic              dest_ok;
  logic              push;
  logic              pop;

  // in_ready looks only at the registered count, never at a same-cycle pop
  assign bus.in_ready = (count != CNT_W'(DEPTH));
  assign take         = bus.in_valid && bus.in_ready;
  assign dest_ok      = ({1'b0, bus.in_dest} < DST1_W'(PORT_NUB));
  assign push         = take && dest_ok;
  assign pop          = bus.grant_in && (bus.vaild_out != '0);

  // head is a prefetch register so the outputs reset to zero while memory does not
  assign {bus.dest_out, bus.data_out} = head;

  // one-hot request for the head word, suppressed while its destination is full
  always_comb begin
    bus.vaild_out = '0;
    for (int k = 0; k < PORT_NUB; k++) begin
      if ((count != '0) && (bus.dest_out == DEST_W'(k)) && !bus.full_in[k]) begin
        bus.vaild_out[k] = 1'b1;
      end
    end
  end

  // word storage; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_dest, bus.in_data};
    end
  end

  // pointers, occupancy, head prefetch and status counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      dest_err <= 1'b0;
      acc_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      // the incoming word becomes head when nothing else will be left in the queue
      if (push && ((count == '0) || (pop && (count == CNT_W'(1))))) begin
        head <= {bus.in_dest, bus.in_data};
      end else if (pop && (count > CNT_W'(1))) begin
        head <= mem[rd_ptr + PTR_W'(1)];
      end
      if (take && !dest_ok) begin
        dest_err <= 1'b1;
      end
      if (push && (acc_cnt != 16'hFFFF)) begin
        acc_cnt <= acc_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_port_in_buffer.sv
// tb/tb_port_in_buffer.sv - self-checking bench for port_in_buffer with a queue-based reference model
module tb_port_in_buffer;
  typedef logic [9:0] word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0]  count4, count3;
  logic        err4, err3;
  logic [15:0] acc4, acc3;

  int total = 0;
  int bad   = 0;

  word_t mq4[$];
  word_t mq3[$];
  bit    merr3;
  int    macc4, macc3;

  port_in_buffer_if #(.PORT_NUB(4), .DATA_WIDTH(8)) b4 ();
  port_in_buffer_if #(.PORT_NUB(3), .DATA_WIDTH(8)) b3 ();

  port_in_buffer #(.PORT_NUB(4), .DATA_WIDTH(8), .DEPTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4), .count(count4), .dest_err(err4), .acc_cnt(acc4)
  );
  port_in_buffer #(.PORT_NUB(3), .DATA_WIDTH(8), .DEPTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .count(count3), .dest_err(err3), .acc_cnt(acc3)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ev4();
    ev4 = '0;
    if (mq4.size() != 0 && !b4.full_in[mq4[0][9:8]]) ev4[mq4[0][9:8]] = 1'b1;
  endfunction

  function automatic logic [2:0] ev3();
    ev3 = '0;
    if (mq3.size() != 0 && !b3.full_in[mq3[0][9:8]]) ev3[mq3[0][9:8]] = 1'b1;
  endfunction

  task automatic clear_model();
    mq4.delete(); mq3.delete();
    merr3 = 0; macc4 = 0; macc3 = 0;
  endtask

  task automatic idle();
    b4.in_valid = 0; b4.grant_in = 0; b4.full_in = '0; b4.in_dest = '0; b4.in_data = '0;
    b3.in_valid = 0; b3.grant_in = 0; b3.full_in = '0; b3.in_dest = '0; b3.in_data = '0;
  endtask

  // one clock edge: the model decides push/pop from the rules, then the edge happens
  task automatic tick();
    bit p4, g4, t3, p3, g3;
    word_t w4, w3;
    w4 = {b4.in_dest, b4.in_data};
    w3 = {b3.in_dest, b3.in_data};
    p4 = b4.in_valid && mq4.size() < 8;
    g4 = b4.grant_in && ev4() != 0;
    t3 = b3.in_valid && mq3.size() < 8;
    p3 = t3 && b3.in_dest < 3;
    g3 = b3.grant_in && ev3() != 0;
    @(posedge clk);
    if (g4) void'(mq4.pop_front());
    if (p4) begin mq4.push_back(w4); if (macc4 < 65535) macc4++; end
    if (g3) void'(mq3.pop_front());
    if (p3) begin mq3.push_back(w3); if (macc3 < 65535) macc3++; end
    if (t3 && !p3) merr3 = 1;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    total++; if (count4 !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count4); end
    total++; if (b4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", b4.in_ready); end
    total++; if (b4.vaild_out !== 4'b0) begin bad++; $display("FAIL reset_vaild got=%b exp=0000", b4.vaild_out); end
    total++; if ({b4.dest_out, b4.data_out} !== 10'd0) begin bad++; $display("FAIL reset_head got=%h exp=000", {b4.dest_out, b4.data_out}); end
    total++; if ({err4, acc4, err3, acc3, count3} !== 38'd0) begin bad++; $display("FAIL reset_status got=%h exp=0", {err4, acc4, err3, acc3, count3}); end
    rst_n = 1;
  endtask

  task automatic test_single();
    b4.in_valid = 1; b4.in_dest = 2; b4.in_data = 8'hA5;
    tick();
    idle();
    #1;
    total++; if (b4.vaild_out !== 4'b0100) begin bad++; $display("FAIL single_vaild got=%b exp=0100", b4.vaild_out); end
    total++; if (b4.data_out !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", b4.data_out); end
    total++; if (count4 !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count4); end
    b4.grant_in = 1;
    tick();
    b4.grant_in = 0;
    #1;
    total++; if ({count4, b4.vaild_out} !== 8'h00) begin bad++; $display("FAIL single_pop got=%h exp=00", {count4, b4.vaild_out}); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      b4.in_valid = 1; b4.in_dest = 2'($urandom); b4.in_data = 8'($urandom);
      tick();
    end
    b4.in_dest = 2'($urandom); b4.in_data = 8'($urandom);
    #1;
    total++; if ({count4, b4.in_ready} !== 5'b1000_0) begin bad++; $display("FAIL fill_full got=%b exp=10000", {count4, b4.in_ready}); end
    tick();
    total++; if (count4 !== 4'd8 || {b4.dest_out, b4.data_out} !== mq4[0]) begin bad++; $display("FAIL fill_held got=%0d/%h exp=8/%h", count4, {b4.dest_out, b4.data_out}, mq4[0]); end
    b4.grant_in = 1;
    tick();
    b4.grant_in = 0; b4.in_valid = 0;
    #1;
    total++; if ({count4, b4.in_ready} !== 5'b0111_1) begin bad++; $display("FAIL fill_after_grant got=%b exp=01111", {count4, b4.in_ready}); end
    b4.grant_in = 1;
    for (int i = 0; i < 7; i++) begin
      total++; if ({b4.dest_out, b4.data_out} !== mq4[0]) begin bad++; $display("FAIL fill_drain idx=%0d got=%h exp=%h", i, {b4.dest_out, b4.data_out}, mq4[0]); end
      tick();
    end
    idle();
    total++; if (count4 !== 4'd0) begin bad++; $display("FAIL fill_empty got=%0d exp=0", count4); end
  endtask

  task automatic test_full_block();
    do_reset();
    b4.in_valid = 1; b4.in_dest = 1; b4.in_data = 8'h3C;
    tick();
    idle();
    b4.full_in = 4'b0010;
    #1;
    total++; if (b4.vaild_out !== 4'b0000) begin bad++; $display("FAIL block_vaild got=%b exp=0000", b4.vaild_out); end
    b4.grant_in = 1;
    tick();
    b4.grant_in = 0;
    total++; if (count4 !== 4'd1) begin bad++; $display("FAIL block_grant_ignored got=%0d exp=1", count4); end
    b4.full_in = 4'b0000;
    #1;
    total++; if (b4.vaild_out !== 4'b0010) begin bad++; $display("FAIL block_release got=%b exp=0010", b4.vaild_out); end
    b4.grant_in = 1;
    tick();
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b4.in_valid = 1; b4.in_dest = 2'($urandom); b4.in_data = 8'($urandom);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      b4.in_valid = 1; b4.grant_in = 1; b4.in_dest = 2'($urandom); b4.in_data = 8'($urandom);
      #1;
      total++; if (count4 !== 4'd3 || {b4.dest_out, b4.data_out} !== mq4[0]) begin bad++; $display("FAIL wrap cyc=%0d got=%0d/%h exp=3/%h", i, count4, {b4.dest_out, b4.data_out}, mq4[0]); end
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    logic [25:0] g4, e4;
    logic [24:0] g3, e3;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      b4.in_valid = 1'($urandom_range(0, (i < 200) ? 3 : 1) != 0);
      b4.grant_in = 1'($urandom_range(0, (i < 200) ? 2 : 0) == 0);
      b4.full_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      b4.in_dest  = 2'($urandom); b4.in_data = 8'($urandom);
      b3.in_valid = 1'($urandom_range(0, 1));
      b3.grant_in = 1'($urandom_range(0, 1));
      b3.full_in  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
      b3.in_dest  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      b3.in_data  = 8'($urandom);
      #1;
      g4 = {count4, b4.in_ready, b4.vaild_out, err4, acc4};
      e4 = {4'(mq4.size()), mq4.size() != 8, ev4(), 1'b0, 16'(macc4)};
      total++; if (g4 !== e4) begin bad++; $display("FAIL rand4_state cyc=%0d got=%h exp=%h", i, g4, e4); end
      g3 = {count3, b3.in_ready, b3.vaild_out, err3, acc3};
      e3 = {4'(mq3.size()), mq3.size() != 8, ev3(), merr3, 16'(macc3)};
      total++; if (g3 !== e3) begin bad++; $display("FAIL rand3_state cyc=%0d got=%h exp=%h", i, g3, e3); end
      if (mq4.size() != 0) begin
        total++; if ({b4.dest_out, b4.data_out} !== mq4[0]) begin bad++; $display("FAIL rand4_head cyc=%0d got=%h exp=%h", i, {b4.dest_out, b4.data_out}, mq4[0]); end
      end
      if (mq3.size() != 0) begin
        total++; if ({b3.dest_out, b3.data_out} !== mq3[0]) begin bad++; $display("FAIL rand3_head cyc=%0d got=%h exp=%h", i, {b3.dest_out, b3.data_out}, mq3[0]); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_bad_dest();
    do_reset();
    b3.in_valid = 1; b3.in_dest = 2'd3; b3.in_data = 8'h77;
    tick();
    total++; if ({count3, err3, acc3} !== {4'd0, 1'b1, 16'd0}) begin bad++; $display("FAIL bad_dest_drop got=%h exp=%h", {count3, err3, acc3}, {4'd0, 1'b1, 16'd0}); end
    b3.in_dest = 2'd0; b3.in_data = 8'h11;
    tick();
    b3.in_dest = 2'd2; b3.in_data = 8'h22;
    tick();
    total++; if ({count3, err3, acc3} !== {4'd2, 1'b1, 16'd2}) begin bad++; $display("FAIL bad_dest_sticky got=%h exp=%h", {count3, err3, acc3}, {4'd2, 1'b1, 16'd2}); end
    total++; if (b3.vaild_out !== 3'b001) begin bad++; $display("FAIL bad_dest_head got=%b exp=001", b3.vaild_out); end
    b3.grant_in = 1;
    #2;
    rst_n = 0;
    #1;
    total++; if ({count3, err3, b3.vaild_out, acc3} !== 24'd0) begin bad++; $display("FAIL async_reset got=%h exp=0", {count3, err3, b3.vaild_out, acc3}); end
    idle();
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_saturate();
    do_reset();
    b4.in_valid = 1; b4.grant_in = 1;
    for (int i = 0; i < 65540; i++) begin
      b4.in_dest = 2'($urandom); b4.in_data = 8'($urandom);
      tick();
    end
    idle();
    total++; if (acc4 !== 16'hFFFF) begin bad++; $display("FAIL saturate_acc got=%h exp=ffff", acc4); end
    total++; if (count4 !== 4'(mq4.size())) begin bad++; $display("FAIL saturate_count got=%0d exp=%0d", count4, mq4.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_block();
    test_wrap();
    test_random();
    test_bad_dest();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
